// File: rtl/lab4_4_scan_ctl.sv
// lab4_4_scan_ctl - time-multiplexed scan controller for a 4-digit
// common-anode seven-segment display.
//
// One shared BCD-to-segment decoder is fed one digit per scan slot. Display
// data is double-buffered: loads land in a shadow register and are committed
// to the displayed value only at frame boundaries, so a frame never mixes
// digits from two different values.
//
// Parameters:
//   SCAN_DIV  clk cycles per digit slot (2 .. 2^20)
//   DIV_W     divider width, 2^DIV_W >= SCAN_DIV
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bcd_in      four BCD nibbles, [3:0] = digit 0 (rightmost)
//   load        capture strobe for bcd_in into the shadow register
//   i           BCD nibble of the selected digit (decoder input)
//   ssd_ctl     active-low digit enables, bit n enables digit n
//   pending     shadow holds a value not yet committed
//   frame_tick  one-cycle pulse on each frame commit
//
// Build option:
//   LEADING_ZERO_BLANK_EN  blank digits 3..1 while they and every more
//                          significant nibble are zero

module lab4_4_scan_ctl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [3:0]  i,
    output logic [3:0]  ssd_ctl,
    output logic        pending,
    output logic        frame_tick
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       i_q, i_d;
    logic [3:0]       ssd_q, ssd_d;

    logic             tick;
    logic             commit;
    logic [3:0]       nib;
    logic             blank;
    logic [3:0]       sel;

    always_comb begin
        tick   = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        commit = tick && (idx_q == 2'd3);
        idx_d  = tick ? idx_q + 2'd1 : idx_q;

        disp_d       = commit ? shadow_q : disp_q;
        shadow_d     = load ? bcd_in : shadow_q;
        frame_tick_d = commit;

        // A load on the commit edge refills the shadow after the old value
        // was taken, so the new value stays pending for the next frame.
        if (load)
            pending_d = 1'b1;
        else if (commit)
            pending_d = 1'b0;
        else
            pending_d = pending_q;

        // Registered digit outputs use the incoming index and display value
        // so the slot content changes on exactly the same edge as idx.
        nib   = disp_d[{idx_d, 2'b00} +: 4];
        blank = (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd1:    blank = blank || (disp_d[15:4]  == 12'd0);
            2'd2:    blank = blank || (disp_d[15:8]  == 8'd0);
            2'd3:    blank = blank || (disp_d[15:12] == 4'd0);
            default: blank = blank;
        endcase
`endif
        sel   = ~(4'b0001 << idx_d);

        i_d   = tick ? nib : i_q;
        ssd_d = tick ? (blank ? '1 : sel) : ssd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            i_q          <= 4'd0;
            ssd_q        <= 4'b1110;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            i_q          <= i_d;
            ssd_q        <= ssd_d;
        end
    end

    assign i          = i_q;
    assign ssd_ctl    = ssd_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_lab4_4_scan_ctl.sv
// Testbench for lab4_4_scan_ctl with SCAN_DIV=4. Stimulus steps one clock at
// a time; a reference model derived from the edge count since reset release
// pushes the expected outputs, and a monitor pops and compares them.

module tb_lab4_4_scan_ctl;

    localparam int unsigned SD    = 4;
    localparam int unsigned FRAME = 4 * SD;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        load;
    logic [3:0]  i;
    logic [3:0]  ssd_ctl;
    logic        pending;
    logic        frame_tick;

    lab4_4_scan_ctl #(.SCAN_DIV(SD), .DIV_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .i(i), .ssd_ctl(ssd_ctl), .pending(pending), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned n;
        logic [3:0]  i;
        logic [3:0]  ssd;
        logic        pend;
        logic        ft;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   in_reset = 1'b1;

    // Reference model state
    int unsigned n;
    logic [15:0] m_shadow, m_disp;
    logic        m_pend;

    task automatic model_reset();
        n        = 0;
        m_shadow = '0;
        m_disp   = '0;
        m_pend   = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] data);
        exp_t        e;
        int unsigned idx;
        logic [3:0]  nib;
        logic [15:0] upper;
        bit          blank;
        bit          commit;
        load   = ld;
        bcd_in = data;
        @(posedge clk);
        #1;
        n++;
        commit = (n % FRAME) == 0;
        if (commit) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_shadow = data;
            m_pend   = 1'b1;
        end
        idx   = (n / SD) % 4;
        upper = m_disp >> (4 * idx);
        nib   = upper[3:0];
        blank = nib > 4'd9;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && upper == 16'd0) blank = 1'b1;
`endif
        e.n    = n;
        e.i    = nib;
        e.ssd  = blank ? 4'b1111 : (4'b1111 & ~(4'b0001 << idx));
        e.pend = m_pend;
        e.ft   = commit;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_to(input int unsigned target, input logic [15:0] data);
        while (n + 1 < target) step(1'b0, 16'h0000);
        step(1'b1, data);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (i !== 4'd0 || ssd_ctl !== 4'b1110 || pending !== 1'b0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL %s: got i=%h ssd=%b pend=%b ft=%b, want i=0 ssd=1110 pend=0 ft=0",
                     tag, i, ssd_ctl, pending, frame_tick);
        end
    endtask

    // Monitor: compares every registered output against the queued model
    always @(negedge clk) begin
        exp_t e;
        if (!in_reset && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (i !== e.i || ssd_ctl !== e.ssd || pending !== e.pend || frame_tick !== e.ft) begin
                fails++;
                $display("FAIL scoreboard edge %0d: got i=%h ssd=%b pend=%b ft=%b, want i=%h ssd=%b pend=%b ft=%b",
                         e.n, i, ssd_ctl, pending, frame_tick, e.i, e.ssd, e.pend, e.ft);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        bcd_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Load while idx=1, collide a new load with the commit edge,
        // then an invalid nibble and leading-zero patterns.
        run_to(5, 16'h1234);
        run_to(FRAME, 16'h5678);
        run_to(3 * FRAME + 2, 16'h12A4);
        run_to(5 * FRAME + 7, 16'h0040);
        run_to(7 * FRAME + 1, 16'h0000);
        run_to(9 * FRAME + 3, 16'h9999);
        run_to(10 * FRAME, 16'h0305);
        while ((n % FRAME) != 9) step(1'b0, 16'h0000);

        // Asynchronous reset mid-frame (idx=2, pending=1)
        #1;
        in_reset = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        q.delete();
        model_reset();
        rst_n    = 1'b1;
        in_reset = 1'b0;

        repeat (2 * FRAME + 3) step(1'b0, 16'h0000);

        // Randomised traffic, including invalid nibbles and commit collisions
        for (int k = 0; k < 600; k++) begin
            logic        ld;
            logic [15:0] d;
            ld = ($urandom_range(0, 5) == 0) || (((n + 1) % FRAME) == 0 && $urandom_range(0, 1) == 1);
            d  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
            step(ld, d);
        end

        #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d entries left, want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
